uart_tx_buffer: RTL
===================

# uart_tx_buffer

Byte-wide elastic buffer between the performance-event serializer (`counter_2`, which emits one `wr_en` pulse per byte) and the UART transmitter `TX_2`. It absorbs bursts of event bytes produced at `clk_cpu` rate and hands them to the transmitter one at a time, honouring its `ready`/`tx_start` handshake. Overflowed bytes are dropped and counted, never stalled back into the event source. It replaces the single-entry `data_separator` stage on the TX path.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2.
- `HOLDOFF`, 2, cycles after a launch during which TX `ready` is ignored; ≥ 1.
- `DROP_W`, 16, width of the drop counter.
- `clk`  in  1  single clock (`clk_cpu` domain); all logic on the rising edge.
- `rstn`  in  1  reset; synchronous, active-low.
- `data_i`  in  8  byte from the event serializer.
- `valid_pulse_i`  in  1  one-cycle write strobe for `data_i`.
- `ready`  in  1  TX idle and able to accept a byte.
- `flush_i`  in  1  synchronous discard of all buffered bytes.
- `clear_stats_i`  in  1  clears `overflow_o` and `drop_cnt_o`.
- `data_o`  out  8  byte to TX `din`; registered.
- `valid_o`  out  1  one-cycle `tx_start` pulse.
- `count_o`  out  $clog2(DEPTH)+1  current occupancy.
- `full_o`, `empty_o`  out  1  occupancy flags; registered.
- `overflow_o`  out  1  sticky; set on any dropped byte.
- `drop_cnt_o`  out  DROP_W  saturating count of dropped bytes.

## Operation
- Storage: circular buffer. Write and read pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is kept in `count_o`, not derived from the pointers.
- Push: `valid_pulse_i` is accepted when `!full_o`, or when a pop occurs in the same cycle. On acceptance, `mem[wr_ptr] <= data_i` and `wr_ptr` increments.
- Drop: `valid_pulse_i` while full with no same-cycle pop discards the byte. It sets `overflow_o` and increments `drop_cnt_o`, which saturates at all-ones.
- Drain FSM, states IDLE and HOLD:
  - IDLE: if `!empty_o && ready`, pop: `data_o <= mem[rd_ptr]`, `valid_o <= 1`, `rd_ptr` increments, hold counter `<= HOLDOFF-1`, go to HOLD.
  - HOLD: `valid_o <= 0`. When the hold counter is 0, go to IDLE; otherwise decrement.
  - IDLE with empty or `!ready`: no action.
- Simultaneous push and pop: `count_o` is unchanged and both pointers advance. This is legal when full and when count is 1.
- `flush_i` has priority over push and pop in its cycle:
  - Pointers go to 0, `count_o` to 0, `empty_o` to 1.
  - The FSM finishes any HOLD normally; a byte already launched is not recalled.
  - A push in the same cycle is discarded and is not counted as a drop.
- `clear_stats_i` zeroes the stats. If a drop occurs in the same cycle, the drop wins: `drop_cnt_o` = 1 and `overflow_o` = 1.
- `data_o` holds the last popped byte between launches.

## Timing
- Reset (`rstn`=0 at an edge): `data_o`=0, `valid_o`=0, `count_o`=0, `empty_o`=1, `full_o`=0, `overflow_o`=0, `drop_cnt_o`=0, pointers 0, FSM in IDLE. Reset mid-HOLD abandons the hold.
- Latency: a byte pushed at edge N into an empty buffer, with FSM in IDLE and `ready`=1, appears with `valid_o`=1 after edge N+1. That is 1 cycle from push to launch.
- `valid_o` is exactly one cycle wide. The minimum spacing between launches is HOLDOFF+1 cycles. With HOLDOFF=2, launches occur at most every 3 cycles, plus the time TX keeps `ready` low.
- Flags and `count_o` reflect the state after the current edge. There are no combinational paths from inputs to outputs.

## Structure
- Package `uart_tx_buffer_pkg`: FSM state enum (`ST_IDLE`, `ST_HOLD`) and the default parameter constants.
- One sub-module, `byte_fifo`:
  - Contains storage, pointers, count and flags.
  - Ports: push, pop, flush, din, dout, count, full, empty.
  - Implements the push-when-full-with-pop rule.
- The top level holds the drain FSM, the hold counter and the drop statistics.

## Test plan
- Single byte: after reset, push 0x3C with `ready`=1. `valid_o` pulses one cycle later with `data_o`=0x3C, then `empty_o`=1 and `count_o`=0.
- Burst/backpressure: hold `ready`=0 and push 16 bytes 0x00..0x0F. `full_o`=1 and `count_o`=16. Release `ready`: bytes launch in order 0x00..0x0F, spaced ≥3 cycles apart.
- Overflow: with the buffer full and `ready`=0, push 5 more bytes. `drop_cnt_o`=5, `overflow_o`=1, contents unchanged. Assert `clear_stats_i`: both stats return to 0.
- Full push+pop: with the buffer full, push 0xAA in the same cycle the FSM pops. `count_o` stays 16 and 0xAA is the 16th byte launched after that pop.
- Wrap-around: stream 40 bytes with `ready` toggling pseudo-randomly. Output order matches input order exactly, with zero drops.
- Flush/reset: with 7 bytes queued, assert `flush_i` together with a push. `count_o`=0, no drop counted, no further `valid_o`. Reset during HOLD: all outputs take their reset values on the next edge.

Source files
------------

// File: rtl/uart_tx_buffer_pkg.sv
// Shared types and default parameters for the UART TX elastic buffer.
package uart_tx_buffer_pkg;

   localparam int DEPTH_DEF   = 16;
   localparam int HOLDOFF_DEF = 2;
   localparam int DROP_W_DEF  = 16;

   typedef enum logic {
      ST_IDLE,
      ST_HOLD
   } drain_state_t;

endpackage

// File: rtl/uart_tx_buffer_byte_fifo.sv
// Circular byte store with registered occupancy count and flags.
// Push while full is accepted only when a pop frees the slot in the same cycle.
module byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [7:0]               din,
   output logic [7:0]               dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_nxt;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && !flush && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // NOTE: every output of an always_comb gets a default first so no latch is inferred.
   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop)
         count_nxt = count + CNT_W'(1);
      else if (do_pop && !do_push)
         count_nxt = count - CNT_W'(1);
   end

   // NOTE: storage is deliberately left out of reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (rstn && do_push)
         mem[wr_ptr] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_nxt;
         full  <= (count_nxt == CNT_W'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

endmodule

// File: rtl/uart_tx_buffer.sv
// Elastic byte buffer feeding the UART transmitter: drains one byte per ready
// window with a fixed hold-off, and drops/counts bytes arriving while full.
module uart_tx_buffer
   import uart_tx_buffer_pkg::*;
#(
   parameter int DEPTH   = DEPTH_DEF,
   parameter int HOLDOFF = HOLDOFF_DEF,
   parameter int DROP_W  = DROP_W_DEF
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [7:0]               data_i,
   input  logic                     valid_pulse_i,
   input  logic                     ready,
   input  logic                     flush_i,
   input  logic                     clear_stats_i,
   output logic [7:0]               data_o,
   output logic                     valid_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic                     overflow_o,
   output logic [DROP_W-1:0]        drop_cnt_o
);

   localparam int HOLD_W = $clog2(HOLDOFF) + 1;

   drain_state_t      state;
   logic [HOLD_W-1:0] hold_cnt;
   logic [7:0]        fifo_dout;
   logic              pop;
   logic              drop;

   // Flush wins over a launch in its cycle; a byte arriving at a full buffer is lost unless a pop frees a slot.
   assign pop  = (state == ST_IDLE) && !empty_o && ready && !flush_i;
   assign drop = valid_pulse_i && full_o && !pop && !flush_i;

   byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (valid_pulse_i),
      .pop   (pop),
      .flush (flush_i),
      .din   (data_i),
      .dout  (fifo_dout),
      .count (count_o),
      .full  (full_o),
      .empty (empty_o)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= ST_IDLE;
         hold_cnt <= '0;
         data_o   <= '0;
         valid_o  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  data_o   <= fifo_dout;
                  valid_o  <= 1'b1;
                  hold_cnt <= HOLD_W'(HOLDOFF - 1);
                  state    <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               valid_o <= 1'b0;
               if (hold_cnt == '0)
                  state <= ST_IDLE;
               else
                  hold_cnt <= hold_cnt - HOLD_W'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // A drop coinciding with a clear leaves exactly that one drop recorded.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         overflow_o <= 1'b0;
         drop_cnt_o <= '0;
      end else if (drop) begin
         overflow_o <= 1'b1;
         if (clear_stats_i)
            drop_cnt_o <= DROP_W'(1);
         else if (drop_cnt_o != '1)
            drop_cnt_o <= drop_cnt_o + DROP_W'(1);
      end else if (clear_stats_i) begin
         overflow_o <= 1'b0;
         drop_cnt_o <= '0;
      end
   end

endmodule
